// File: rtl/fb_pixel_writer.sv
// Framebuffer pixel writer: read-modify-write of single 1-bpp pixels and whole-screen fill.
// Commands are taken only in IDLE; all datapath outputs are registered.
//
// state  | meaning
// IDLE   | ready for a command; out-of-range/reserved commands are rejected here with err
// RDWAIT | read address presented, waiting RD_LATENCY cycles for fb_q
// WRITE  | modified word being written (fb_wren/done high this cycle)
// FILL   | streaming one word per cycle over the whole framebuffer
module fb_pixel_writer #(
    parameter int RD_LATENCY     = 1,
    parameter int WORDS_PER_LINE = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [9:0]  cmd_x,
    input  logic [8:0]  cmd_y,
    input  logic        cmd_color,
    output logic [14:0] fb_rdaddress,
    input  logic [31:0] fb_q,
    output logic [14:0] fb_wraddress,
    output logic [31:0] fb_data,
    output logic        fb_wren,
    output logic        busy,
    output logic        err,
    output logic        done
);

    localparam int          NUM_LINES = 480;
    localparam int          FB_WORDS  = WORDS_PER_LINE * NUM_LINES;
    localparam logic [14:0] LAST_ADDR = 15'(FB_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RDWAIT = 2'd1,
        WRITE  = 2'd2,
        FILL   = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  op_q;
    logic [4:0]  bit_q;
    logic        color_q;
    logic [1:0]  lat_cnt;
    logic [14:0] fill_cnt;
    logic [14:0] word_addr;
    logic [31:0] wr_word;
    logic        accept, in_range, start_pixel, start_fill, reject;
    logic        lat_done, fill_last;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    assign accept      = cmd_valid && (state == IDLE);
    assign in_range    = (cmd_x < 10'(WORDS_PER_LINE * 32)) && (cmd_y < 9'(NUM_LINES));
    assign start_pixel = accept && !cmd_op[1] && in_range;
    assign start_fill  = accept && (cmd_op == 2'b10);
    assign reject      = accept && !start_pixel && !start_fill;
    assign word_addr   = 15'(cmd_y) * 15'(WORDS_PER_LINE) + 15'(cmd_x[9:5]);
    assign lat_done    = (lat_cnt == 2'd0);
    assign fill_last   = (fill_cnt == 15'd0);

    // Bit 0 is the leftmost pixel; op[0] selects toggle over write.
    always_comb begin
        wr_word        = fb_q;
        wr_word[bit_q] = op_q[0] ? ~fb_q[bit_q] : color_q;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_fill)
                    state_nxt = FILL;
                else if (start_pixel)
                    state_nxt = RDWAIT;
            end
            RDWAIT: if (lat_done) state_nxt = WRITE;
            WRITE:  state_nxt = IDLE;
            FILL:   if (fill_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q         <= 2'b00;
            bit_q        <= 5'd0;
            color_q      <= 1'b0;
            lat_cnt      <= 2'd0;
            fill_cnt     <= 15'd0;
            fb_rdaddress <= 15'd0;
            fb_wraddress <= 15'd0;
            fb_data      <= 32'd0;
            fb_wren      <= 1'b0;
            err          <= 1'b0;
            done         <= 1'b0;
        end else begin
            err     <= reject;
            done    <= 1'b0;
            fb_wren <= 1'b0;
            if (start_pixel) begin
                op_q         <= cmd_op;
                bit_q        <= cmd_x[4:0];
                color_q      <= cmd_color;
                fb_rdaddress <= word_addr;
                lat_cnt      <= 2'(RD_LATENCY);
            end
            if (start_fill) begin
                color_q      <= cmd_color;
                fill_cnt     <= LAST_ADDR;
                fb_wren      <= 1'b1;
                fb_wraddress <= 15'd0;
                fb_data      <= {32{cmd_color}};
            end
            // fb_rdaddress doubles as the held word address for the write-back.
            if (state == RDWAIT) begin
                if (lat_done) begin
                    fb_wren      <= 1'b1;
                    done         <= 1'b1;
                    fb_wraddress <= fb_rdaddress;
                    fb_data      <= wr_word;
                end else begin
                    lat_cnt <= lat_cnt - 2'd1;
                end
            end
            if ((state == FILL) && !fill_last) begin
                fb_wren      <= 1'b1;
                fb_wraddress <= fb_wraddress + 15'd1;
                fill_cnt     <= fill_cnt - 15'd1;
                done         <= (fill_cnt == 15'd1);
            end
        end
    end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Bench for fb_pixel_writer: two instances (RD_LATENCY 1 and 2) with behavioural RAMs,
// checked against a word-array pixel model updated by the command rules.
module tb_fb_pixel_writer;

    logic        clk, reset;
    logic        cmd_valid, cmd_color, sel;
    logic [1:0]  cmd_op;
    logic [9:0]  cmd_x;
    logic [8:0]  cmd_y;

    logic        r1_ready, r1_wren, r1_busy, r1_err, r1_done;
    logic [14:0] r1_rdaddr, r1_wraddr;
    logic [31:0] r1_data, q1;
    logic        r2_ready, r2_wren, r2_busy, r2_err, r2_done;
    logic [14:0] r2_rdaddr, r2_wraddr;
    logic [31:0] r2_data, q2, p2;

    logic [31:0] mem1 [0:9599];
    logic [31:0] mem2 [0:9599];
    logic [31:0] ref_mem [0:1][0:9599];

    int n_tests = 0;
    int n_fail  = 0;

    fb_pixel_writer #(.RD_LATENCY(1), .WORDS_PER_LINE(20)) u_dut1 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid && !sel), .cmd_ready(r1_ready),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_color(cmd_color),
        .fb_rdaddress(r1_rdaddr), .fb_q(q1), .fb_wraddress(r1_wraddr), .fb_data(r1_data),
        .fb_wren(r1_wren), .busy(r1_busy), .err(r1_err), .done(r1_done)
    );

    fb_pixel_writer #(.RD_LATENCY(2), .WORDS_PER_LINE(20)) u_dut2 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid && sel), .cmd_ready(r2_ready),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_color(cmd_color),
        .fb_rdaddress(r2_rdaddr), .fb_q(q2), .fb_wraddress(r2_wraddr), .fb_data(r2_data),
        .fb_wren(r2_wren), .busy(r2_busy), .err(r2_err), .done(r2_done)
    );

    always @(posedge clk) begin
        if (r1_wren) mem1[r1_wraddr] <= r1_data;
        q1 <= mem1[r1_rdaddr];
        if (r2_wren) mem2[r2_wraddr] <= r2_data;
        p2 <= mem2[r2_rdaddr];
        q2 <= p2;
    end

    wire        o_ready  = sel ? r2_ready  : r1_ready;
    wire        o_wren   = sel ? r2_wren   : r1_wren;
    wire        o_busy   = sel ? r2_busy   : r1_busy;
    wire        o_err    = sel ? r2_err    : r1_err;
    wire        o_done   = sel ? r2_done   : r1_done;
    wire [14:0] o_rdaddr = sel ? r2_rdaddr : r1_rdaddr;
    wire [14:0] o_wraddr = sel ? r2_wraddr : r1_wraddr;
    wire [31:0] o_data   = sel ? r2_data   : r1_data;
    wire [31:0] o_q      = sel ? q2        : q1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t sel=%0d)", tag, obs, exp, $time, sel);
        end
    endtask

    task automatic do_pixel(input logic [1:0] op, input int x, input int y, input logic c);
        int          lat, addr, bitn, wren_seen;
        bit          in_rng;
        logic [31:0] exp_old, exp_new;
        lat    = sel ? 2 : 1;
        in_rng = (op != 2'b11) && (x < 640) && (y < 480);
        addr   = in_rng ? (y * 20 + x / 32) : 0;
        bitn   = x % 32;
        exp_old = ref_mem[sel][addr];
        exp_new = exp_old;
        if (op == 2'b01) exp_new[bitn] = ~exp_old[bitn];
        else             exp_new[bitn] = c;
        check("ready_before_cmd", o_ready, 1);
        cmd_op = op; cmd_x = 10'(x); cmd_y = 9'(y); cmd_color = c; cmd_valid = 1'b1;
        @(posedge clk);
        wren_seen = 0;
        for (int k = 1; k <= lat + 3; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cmd_valid = 1'b0;
                cmd_x = 10'($urandom);
                cmd_op = 2'($urandom);
            end
            if (o_wren) wren_seen++;
            if (in_rng) begin
                if (k == 1) begin
                    check("rdaddress", o_rdaddr, addr);
                    check("busy_after_accept", o_busy, 1);
                end
                if (k == lat + 1) check("read_data", o_q, exp_old);
                if (k == lat + 2) begin
                    check("wren_at_write", o_wren, 1);
                    check("wraddress", o_wraddr, addr);
                    check("write_data", o_data, exp_new);
                    check("done_with_write", o_done, 1);
                    check("rdaddress_held", o_rdaddr, addr);
                end
                if (k == lat + 3) begin
                    check("ready_after_write", o_ready, 1);
                    check("done_one_cycle", o_done, 0);
                end
            end else begin
                if (k == 1) begin
                    check("err_pulse", o_err, 1);
                    check("ready_after_reject", o_ready, 1);
                    check("no_done_on_reject", o_done, 0);
                end
                if (k == 2) check("err_one_cycle", o_err, 0);
            end
        end
        check("wren_count", wren_seen, in_rng ? 1 : 0);
        if (in_rng) ref_mem[sel][addr] = exp_new;
    endtask

    task automatic do_fill(input logic c, input int abort_after);
        int cnt;
        bit addr_ok, data_ok, ready_low, done_ok, aborted;
        cnt = 0; addr_ok = 1; data_ok = 1; ready_low = 1; done_ok = 1; aborted = 0;
        check("ready_before_fill", o_ready, 1);
        cmd_op = 2'b10; cmd_x = 10'($urandom); cmd_y = 9'($urandom); cmd_color = c; cmd_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 9601; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            if (abort_after != 0 && k == abort_after + 1) begin
                reset = 1'b1;
                #1;
                check("abort_wren_low", o_wren, 0);
                check("abort_idle", o_busy, 0);
                aborted = 1;
                break;
            end
            if (k <= 9600) begin
                if (o_wren) begin
                    if (o_wraddr != 15'(cnt)) addr_ok = 0;
                    if (o_data != {32{c}}) data_ok = 0;
                    cnt++;
                end
                if (o_ready) ready_low = 0;
                if (o_done != (k == 9600)) done_ok = 0;
            end else begin
                check("ready_after_fill", o_ready, 1);
                check("wren_low_after_fill", o_wren, 0);
            end
        end
        if (aborted) begin
            check("fill_count_before_abort", cnt, abort_after);
            for (int i = 0; i < abort_after; i++) ref_mem[sel][i] = {32{c}};
            @(negedge clk);
            reset = 1'b0;
            @(posedge clk);
            #1;
            check("ready_after_reset", o_ready, 1);
            @(negedge clk);
        end else begin
            check("fill_count", cnt, 9600);
            check("fill_addr_order", 32'(addr_ok), 1);
            check("fill_data", 32'(data_ok), 1);
            check("fill_ready_low", 32'(ready_low), 1);
            check("fill_done_last", 32'(done_ok), 1);
            for (int i = 0; i < 9600; i++) ref_mem[sel][i] = {32{c}};
        end
    endtask

    initial begin
        reset = 1'b1; sel = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00;
        cmd_x = 10'd0; cmd_y = 9'd0; cmd_color = 1'b0;
        for (int i = 0; i < 9600; i++) begin
            ref_mem[0][i] = 32'd0;
            ref_mem[1][i] = 32'd0;
        end
        repeat (3) @(negedge clk);
        check("rst_wren", r1_wren, 0);
        check("rst_err", r1_err, 0);
        check("rst_done", r1_done, 0);
        check("rst_rdaddress", r1_rdaddr, 0);
        check("rst_wraddress", r1_wraddr, 0);
        check("rst_data", r1_data, 0);
        check("rst_ready", r1_ready, 1);
        reset = 1'b0;
        @(negedge clk);

        // Rejections first: nothing has touched the framebuffer yet.
        do_pixel(2'b00, 640, 0, 1'b1);
        do_pixel(2'b11, 5, 5, 1'b1);
        do_pixel(2'b01, 10, 480, 1'b0);

        do_fill(1'b0, 0);
        do_pixel(2'b00, 37, 2, 1'b1);
        do_fill(1'b1, 0);
        do_pixel(2'b01, 639, 479, 1'b0);
        do_fill(1'b0, 100);
        do_pixel(2'b00, 3, 0, 1'b1);

        // Bias toward the partially filled region so both halves get exercised.
        for (int i = 0; i < 40; i++) begin
            int r, x, y;
            r = int'($urandom_range(0, 9));
            x = int'($urandom_range(0, 639));
            y = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 479));
            if (r <= 3)      do_pixel(2'b00, x, y, 1'($urandom));
            else if (r <= 6) do_pixel(2'b01, x, y, 1'($urandom));
            else if (r == 7) do_pixel(2'b11, x, y, 1'($urandom));
            else if (r == 8) do_pixel(2'b00, int'($urandom_range(640, 1023)), y, 1'b1);
            else             do_pixel(2'b01, x, int'($urandom_range(480, 511)), 1'b1);
        end

        sel = 1'b1;
        @(negedge clk);
        do_fill(1'b0, 0);
        do_pixel(2'b00, 0, 0, 1'b1);
        do_pixel(2'b00, 1, 0, 1'b1);
        for (int i = 0; i < 12; i++)
            do_pixel(2'($urandom_range(0, 1)), int'($urandom_range(0, 95)), int'($urandom_range(0, 1)), 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_pixel_writer.md
FB_PIXEL_WRITER -- requirements
Module: fb_pixel_writer

Interface
REQ-001 Parameter: RD_LATENCY, default 1, framebuffer read-port latency in cycles (legal values 1 or 2).
REQ-002 Parameter: WORDS_PER_LINE, default 20, 32-bit words per 640-pixel row.
REQ-003 Port: clk  input  1  system clock; all logic rising-edge.
REQ-004 Port: reset  input  1  asynchronous, active-high.
REQ-005 Port: cmd_valid  input  1  command offered.
REQ-006 Port: cmd_ready  output  1  command accepted on the cycle where cmd_valid and cmd_ready are both high.
REQ-007 Port: cmd_op  input  2  opcode: 00 = write pixel, 01 = toggle pixel, 10 = fill screen, 11 = reserved.
REQ-008 Port: cmd_x  input  10  pixel column.
REQ-009 Port: cmd_y  input  9  pixel row.
REQ-010 Port: cmd_color  input  1  pixel or fill value (1 = white).
REQ-011 Port: fb_rdaddress  output  15  writer-side framebuffer read address.
REQ-012 Port: fb_q  input  32  read data, valid RD_LATENCY cycles after fb_rdaddress.
REQ-013 Port: fb_wraddress  output  15  framebuffer write address.
REQ-014 Port: fb_data  output  32  framebuffer write data.
REQ-015 Port: fb_wren  output  1  write strobe, one word per high cycle.
REQ-016 Port: busy  output  1  high in any state other than IDLE.
REQ-017 Port: err  output  1  one-cycle pulse for a rejected command.
REQ-018 Port: done  output  1  one-cycle pulse when an accepted command completes.

Function
REQ-019 Pixel mapping: word address = cmd_y*20 + cmd_x[9:5], computed as (y<<4)+(y<<2)+x[9:5] in 15 bits (maximum 9599); bit index = cmd_x[4:0], with bit 0 as the leftmost pixel of the word.
REQ-020 States: IDLE, RDWAIT, WRITE, FILL; cmd_ready = (state == IDLE).
REQ-021 On acceptance, the block SHALL register cmd_op, the computed address, the bit index and cmd_color.
REQ-022 IDLE, op 00/01 in range: go to RDWAIT; fb_rdaddress = word address from T+1; hold fb_rdaddress stable until WRITE completes.
REQ-023 RDWAIT: count RD_LATENCY cycles, then go to WRITE and sample fb_q in that cycle.
REQ-024 WRITE: fb_data = fb_q with only the target bit changed (op 00: set to cmd_color; op 01: inverted); fb_wraddress = word address; fb_wren high for exactly one cycle, at T+RD_LATENCY+2.
REQ-025 WRITE completion: done pulses in the same cycle as fb_wren, and the block returns to IDLE, so cmd_ready is high at T+RD_LATENCY+3.
REQ-026 Pixel command throughput: one accepted pixel command per RD_LATENCY+3 cycles; back-to-back commands to the same word SHALL observe the prior write (no write-to-read bypass is needed because the read is issued after the previous write).
REQ-027 Out of range: cmd_x >= 640 or cmd_y >= 480 on op 00/01, or cmd_op == 11: the block SHALL accept the command, perform no read or write, pulse err at T+1, assert no done, and stay in IDLE.
REQ-028 IDLE, op 10: go to FILL; cmd_x, cmd_y and err are ignored.
REQ-029 FILL timing: fb_wren high for 9600 consecutive cycles T+1..T+9600; fb_wraddress runs 0..9599, incrementing by 1; fb_data = {32{cmd_color}}.
REQ-030 FILL completion: done pulses with the write to address 9599, and the block is in IDLE at T+9601.
REQ-031 During FILL, fb_rdaddress SHALL hold its last value.
REQ-032 All outputs SHALL be registered except cmd_ready and busy, which are decoded from state.
REQ-033 When fb_wren is low, fb_data and fb_wraddress hold their last values.
REQ-034 cmd_valid is sampled only in IDLE; inputs outside acceptance cycles are don't-care.

Reset
REQ-035 Reset values: state = IDLE, fb_wren = 0, err = 0, done = 0, fb_rdaddress = 0, fb_wraddress = 0, fb_data = 0, fill counter = 0.
REQ-036 Reset asserted mid-FILL or mid-pixel operation SHALL abort the operation immediately, with no further fb_wren; the partially written framebuffer contents are left as is.
REQ-037 After reset deasserts, cmd_ready SHALL be high on the first clock edge.

Verification
REQ-038 Write pixel: op 00, x=37, y=2, color 1, fb_q=0x00000000 -> fb_rdaddress=41, one fb_wren at T+3 (RD_LATENCY=1) with fb_wraddress=41 and fb_data=0x00000020, done pulse, cmd_ready high at T+4.
REQ-039 Toggle pixel: op 01, x=639, y=479, fb_q=0xFFFFFFFF -> fb_wraddress=9599, fb_data=0x7FFFFFFF.
REQ-040 Out-of-range write: op 00, x=640, y=0 -> err pulse at T+1, fb_wren never asserted, cmd_ready high at T+1; repeat with op 11 -> same response.
REQ-041 Fill: op 10, color 1 -> exactly 9600 fb_wren cycles, addresses 0..9599 in order, data 0xFFFFFFFF, done at the final write, cmd_ready low throughout the fill.
REQ-042 Reset during fill: assert reset after 100 fill writes -> fb_wren low immediately; after release, state = IDLE and a following op 00 completes normally.
REQ-043 Latency parameter: RD_LATENCY=2 run with two back-to-back pixel writes to the same word (x=0 and x=1, y=0) -> the second read returns 0x00000001 and the second write data is 0x00000003.
